// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI responder that oversamples SCLK/MOSI/SS in the clk domain.
// Received words leave on a valid/ready stream. Words to send arrive on a
// valid/ready stream.
// Optional status flags (overrun/underrun/status_clr) are built when
// SPI_SLAVE_STATUS_EN is defined.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ssn high, waiting for a synced ssn falling edge
// ACTIVE | frame in progress; SCLK edges shift rx/tx, MISO driven
// ABORT  | after reset: wait for the synchronisers to flush, then wait for
//        | ssn high so a frame already in flight is never received

module spi_slave #(
    parameter int          DW            = 8,
    parameter bit          CPOL          = 1'b0,
    parameter bit          CPHA          = 1'b0,
    parameter logic [DW-1:0] UNDERRUN_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk_i,
    input  logic          mosi_i,
    input  logic          ssn_i,
    output logic          miso_o,
    output logic          miso_tn,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic          status_clr,
    output logic          overrun,
    output logic          underrun,
`endif
    output logic          busy
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            sclk_s1, sclk_s2, sclk_s3;
    logic            ssn_s1, ssn_s2, ssn_s3;
    logic            mosi_s1, mosi_s2;
    logic [1:0]      settle;

    logic [CW-1:0]   cnt;
    logic [DW-2:0]   rx_sh;
    logic [DW-1:0]   rx_word;
    logic [DW-1:0]   tx_sh;
    logic [DW-1:0]   tx_sh_nxt;

    logic            active;
    logic            sclk_edge;
    logic            lead_edge;
    logic            trail_edge;
    logic            sample_edge;
    logic            drive_edge;
    logic            ssn_fall;
    logic            enter_active;
    logic            leave_active;
    logic            word_done;
    logic            load;

    // Two-flop synchronisers; SCLK and SSN get a third flop for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_s3 <= CPOL;
            ssn_s1  <= 1'b1;
            ssn_s2  <= 1'b1;
            ssn_s3  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ssn_s1  <= ssn_i;
            ssn_s2  <= ssn_s1;
            ssn_s3  <= ssn_s2;
            mosi_s1 <= mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    // Post-reset hold-off until the synchronisers carry real pin values.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle <= 2'd3;
        end else if (settle != 2'd0) begin
            settle <= settle - 2'd1;
        end
    end

    assign active       = (state == ST_ACTIVE);
    assign sclk_edge    = active && (sclk_s2 != sclk_s3);
    assign lead_edge    = sclk_edge && (sclk_s2 != CPOL);
    assign trail_edge   = sclk_edge && (sclk_s2 == CPOL);
    assign sample_edge  = CPHA ? trail_edge : lead_edge;
    assign drive_edge   = CPHA ? lead_edge : trail_edge;
    assign ssn_fall     = !ssn_s2 && ssn_s3;
    assign enter_active = (state == ST_IDLE) && (state_nxt == ST_ACTIVE);
    assign leave_active = active && (state_nxt != ST_ACTIVE);
    assign word_done    = sample_edge && (cnt == CW'(DW - 1));
    assign rx_word      = {rx_sh, mosi_s2};

    // CPHA=0 must present the first bit before the first SCLK edge, so it
    // also loads when the frame opens.
    assign load = !rst && (((CPHA == 1'b0) && enter_active) ||
                           (drive_edge && (cnt == '0)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ABORT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ssn_fall) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ssn_s2) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if ((settle == 2'd0) && ssn_s2 && ssn_s3) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next transmit shift value; MISO is registered from it so the new bit
    // appears in the same cycle the shift register updates.
    always_comb begin
        tx_sh_nxt = tx_sh;
        if (load) begin
            tx_sh_nxt = tx_valid ? tx_data : UNDERRUN_WORD;
        end else if (drive_edge) begin
            tx_sh_nxt = {tx_sh[DW-2:0], 1'b0};
        end
    end

    // Bit counter, shift registers and the rx stream register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            miso_o   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            tx_sh  <= tx_sh_nxt;
            miso_o <= tx_sh_nxt[DW-1];

            if (enter_active || leave_active) begin
                cnt <= '0;
            end else if (sample_edge) begin
                cnt <= word_done ? '0 : cnt + CW'(1);
            end

            if (sample_edge) begin
                rx_sh <= rx_word[DW-2:0];
            end

            // A completing word always wins; it also overwrites unread data.
            if (word_done) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = load;
    assign busy     = active;
    assign miso_tn  = !active;

`ifdef SPI_SLAVE_STATUS_EN
    logic overrun_set;
    logic underrun_set;

    assign overrun_set  = word_done && rx_valid && !rx_ready;
    assign underrun_set = load && !tx_valid;

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (status_clr) begin
                underrun <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// tb_spi_slave: directed bench driving two responders (mode 0 and mode 3)
// from one bit-banged master. Optional status ports follow SPI_SLAVE_STATUS_EN.

module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phase = 1'b0;
    logic       mosi = 1'b0;
    logic       ssn0 = 1'b1;
    logic       ssn1 = 1'b1;
    logic       sclk0;
    logic       sclk1;

    logic       miso0, miso_tn0, rx_valid0, tx_ready0, busy0;
    logic       miso1, miso_tn1, rx_valid1, tx_ready1, busy1;
    logic [7:0] rx_data0, rx_data1;
    logic [7:0] tx_data0 = 8'h00;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_valid0 = 1'b0;
    logic       tx_valid1 = 1'b0;
    logic       rx_ready0 = 1'b1;
    logic       rx_ready1 = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clr = 1'b0;
    logic       overrun0, underrun0, overrun1, underrun1;
`endif

    int         checks = 0;
    int         errors = 0;

    logic [7:0] rx_log0 [0:63];
    logic [7:0] rx_log1 [0:63];
    int         rxn0 = 0;
    int         rxn1 = 0;
    int         txp0 = 0;
    int         txp1 = 0;

    assign sclk0 = phase;
    assign sclk1 = ~phase;

    always #5 clk = ~clk;

    spi_slave #(.DW(8), .CPOL(1'b0), .CPHA(1'b0), .UNDERRUN_WORD(8'h5A)) dut0 (
        .clk(clk), .rst(rst), .sclk_i(sclk0), .mosi_i(mosi), .ssn_i(ssn0),
        .miso_o(miso0), .miso_tn(miso_tn0), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .rx_ready(rx_ready0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0),
`ifdef SPI_SLAVE_STATUS_EN
        .status_clr(status_clr), .overrun(overrun0), .underrun(underrun0),
`endif
        .busy(busy0)
    );

    spi_slave #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .UNDERRUN_WORD(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .sclk_i(sclk1), .mosi_i(mosi), .ssn_i(ssn1),
        .miso_o(miso1), .miso_tn(miso_tn1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .rx_ready(rx_ready1), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1),
`ifdef SPI_SLAVE_STATUS_EN
        .status_clr(status_clr), .overrun(overrun1), .underrun(underrun1),
`endif
        .busy(busy1)
    );

    // Log accepted rx words and tx_ready pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid0 && rx_ready0 && rxn0 < 64) begin
                rx_log0[rxn0] = rx_data0;
                rxn0 = rxn0 + 1;
            end
            if (rx_valid1 && rx_ready1 && rxn1 < 64) begin
                rx_log1[rxn1] = rx_data1;
                rxn1 = rxn1 + 1;
            end
            if (tx_ready0) txp0 = txp0 + 1;
            if (tx_ready1) txp1 = txp1 + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Master: SCLK = clk/8. d=0 -> dut0 (mode 0), d=1 -> dut1 (mode 3).
    task automatic xfer(input int d, input logic [7:0] mo, input int nbits,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (d == 0) begin
                mosi = mo[7-i];
                half();
                mi = {mi[6:0], miso0};
                phase = 1'b1;
                half();
                phase = 1'b0;
            end else begin
                phase = 1'b1;
                mosi = mo[7-i];
                half();
                mi = {mi[6:0], miso1};
                phase = 1'b0;
                half();
            end
        end
        if (d == 0) half();
    endtask

    task automatic begin_frame(input int d);
        if (d == 0) ssn0 = 1'b0; else ssn1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame(input int d);
        if (d == 0) ssn0 = 1'b1; else ssn1 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso0: got %b expected 0", miso0); end
        checks++; if (miso_tn0 !== 1'b1) begin errors++; $display("FAIL reset_miso_tn0: got %b expected 1", miso_tn0); end
        checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data0: got %h expected 00", rx_data0); end
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid0: got %b expected 0", rx_valid0); end
        checks++; if (tx_ready0 !== 1'b0) begin errors++; $display("FAIL reset_tx_ready0: got %b expected 0", tx_ready0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (miso_tn1 !== 1'b1) begin errors++; $display("FAIL reset_miso_tn1: got %b expected 1", miso_tn1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL reset_overrun0: got %b expected 0", overrun0); end
        checks++; if (underrun0 !== 1'b0) begin errors++; $display("FAIL reset_underrun0: got %b expected 0", underrun0); end
`endif
        repeat (8) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] mi;
        int tb0, rb0;
        tx_data0 = 8'h3C;
        tx_valid0 = 1'b1;
        tb0 = txp0;
        rb0 = rxn0;
        begin_frame(0);
        checks++; if (txp0 - tb0 !== 1) begin errors++; $display("FAIL m0_txready_at_ssn: got %0d expected 1", txp0 - tb0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b expected 1", busy0); end
        checks++; if (miso_tn0 !== 1'b0) begin errors++; $display("FAIL m0_miso_tn: got %b expected 0", miso_tn0); end
        xfer(0, 8'hA5, 8, mi);
        checks++; if (mi !== 8'h3C) begin errors++; $display("FAIL m0_miso_word: got %h expected 3c", mi); end
        end_frame(0);
        checks++; if (rxn0 - rb0 !== 1) begin errors++; $display("FAIL m0_rx_count: got %0d expected 1", rxn0 - rb0); end
        checks++; if (rx_log0[rb0] !== 8'hA5) begin errors++; $display("FAIL m0_rx_word: got %h expected a5", rx_log0[rb0]); end
        // Second pulse is the prefetch at the trailing edge after the last sample.
        checks++; if (txp0 - tb0 !== 2) begin errors++; $display("FAIL m0_txready_total: got %0d expected 2", txp0 - tb0); end
        checks++; if (miso_tn0 !== 1'b1) begin errors++; $display("FAIL m0_miso_tn_end: got %b expected 1", miso_tn0); end
        tx_valid0 = 1'b0;
    endtask

    task automatic test_mode3_multiword();
        logic [7:0] mi;
        logic [7:0] txw [0:2];
        logic [7:0] rxw [0:2];
        int tb1, rb1;
        txw[0] = 8'h11; txw[1] = 8'h22; txw[2] = 8'h33;
        rxw[0] = 8'h01; rxw[1] = 8'h80; rxw[2] = 8'hFF;
        tb1 = txp1;
        rb1 = rxn1;
        begin_frame(1);
        for (int k = 0; k < 3; k++) begin
            tx_data1 = txw[k];
            tx_valid1 = 1'b1;
            xfer(1, rxw[k], 8, mi);
            checks++; if (mi !== txw[k]) begin errors++; $display("FAIL m3_miso_word%0d: got %h expected %h", k, mi, txw[k]); end
        end
        end_frame(1);
        tx_valid1 = 1'b0;
        checks++; if (txp1 - tb1 !== 3) begin errors++; $display("FAIL m3_txready_count: got %0d expected 3", txp1 - tb1); end
        checks++; if (rxn1 - rb1 !== 3) begin errors++; $display("FAIL m3_rx_count: got %0d expected 3", rxn1 - rb1); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rx_log1[rb1+k] !== rxw[k]) begin errors++; $display("FAIL m3_rx_word%0d: got %h expected %h", k, rx_log1[rb1+k], rxw[k]); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        tx_valid0 = 1'b0;
        begin_frame(0);
        xfer(0, 8'h00, 8, mi);
        end_frame(0);
        checks++; if (mi !== 8'h5A) begin errors++; $display("FAIL underrun_word: got %h expected 5a", mi); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (underrun0 !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b expected 1", underrun0); end
        repeat (4) @(negedge clk);
        checks++; if (underrun0 !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun0); end
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
        checks++; if (underrun0 !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun0); end
`endif
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int rb0;
        rx_ready0 = 1'b0;
        rb0 = rxn0;
        begin_frame(0);
        xfer(0, 8'h12, 8, mi);
        xfer(0, 8'h34, 8, mi);
        end_frame(0);
        checks++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid: got %b expected 1", rx_valid0); end
        checks++; if (rx_data0 !== 8'h34) begin errors++; $display("FAIL ovr_rx_data: got %h expected 34", rx_data0); end
`ifdef SPI_SLAVE_STATUS_EN
        checks++; if (overrun0 !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun0); end
`endif
        @(posedge clk);
        #2 rx_ready0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL ovr_accept_clear: got %b expected 0", rx_valid0); end
        checks++; if (rxn0 - rb0 !== 1) begin errors++; $display("FAIL ovr_accept_count: got %0d expected 1", rxn0 - rb0); end
        checks++; if (rx_log0[rb0] !== 8'h34) begin errors++; $display("FAIL ovr_accept_word: got %h expected 34", rx_log0[rb0]); end
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        @(negedge clk);
        checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun0); end
`endif
    endtask

    task automatic test_ssn_midword();
        logic [7:0] mi;
        int rb0;
        rb0 = rxn0;
        begin_frame(0);
        xfer(0, 8'hFF, 5, mi);
        ssn0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (miso_tn0 !== 1'b1) begin errors++; $display("FAIL mid_miso_tn: got %b expected 1", miso_tn0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy0); end
        repeat (8) @(negedge clk);
        checks++; if (rxn0 - rb0 !== 0) begin errors++; $display("FAIL mid_no_rx: got %0d expected 0", rxn0 - rb0); end
        begin_frame(0);
        xfer(0, 8'hC3, 8, mi);
        end_frame(0);
        checks++; if (rxn0 - rb0 !== 1) begin errors++; $display("FAIL mid_next_count: got %0d expected 1", rxn0 - rb0); end
        checks++; if (rx_log0[rb0] !== 8'hC3) begin errors++; $display("FAIL mid_next_word: got %h expected c3", rx_log0[rb0]); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] mi;
        int rb0, tb0;
        begin_frame(0);
        xfer(0, 8'hFF, 3, mi);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rb0 = rxn0;
        tb0 = txp0;
        repeat (6) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy0); end
        checks++; if (miso_tn0 !== 1'b1) begin errors++; $display("FAIL abort_miso_tn: got %b expected 1", miso_tn0); end
        xfer(0, 8'hFF, 5, mi);
        xfer(0, 8'hAA, 8, mi);
        checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL abort_rx_valid: got %b expected 0", rx_valid0); end
        checks++; if (rxn0 - rb0 !== 0) begin errors++; $display("FAIL abort_no_rx: got %0d expected 0", rxn0 - rb0); end
        checks++; if (txp0 - tb0 !== 0) begin errors++; $display("FAIL abort_no_load: got %0d expected 0", txp0 - tb0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy_late: got %b expected 0", busy0); end
        end_frame(0);
        begin_frame(0);
        xfer(0, 8'h96, 8, mi);
        end_frame(0);
        checks++; if (rxn0 - rb0 !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", rxn0 - rb0); end
        checks++; if (rx_log0[rb0] !== 8'h96) begin errors++; $display("FAIL abort_next_word: got %h expected 96", rx_log0[rb0]); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_multiword();
        test_underrun();
        test_overrun();
        test_ssn_midword();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Fabric-side SPI slave (responder) that terminates the PS SPI master's SCLK/MOSI/SS lines and drives MISO back.
- Oversamples all SPI pins in the single system clock domain, with no SCLK-clocked logic.
- Presents received words as a valid/ready stream and accepts words to transmit on a valid/ready stream.
- Sits between the SPI pin/tri-state wrapper and user logic.

Parameters:
- DW, 8, word width in bits; transfers are MSB first; legal values 2..32.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge and drive on trailing edge; 1 = drive on leading edge and sample on trailing edge.
- UNDERRUN_WORD, 0, word shifted out when no tx word is available at a load event.

Ports:
- clk  input  1  system clock; must be at least 4x SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- sclk_i  input  1  SCLK from master (asynchronous).
- mosi_i  input  1  MOSI from master (asynchronous).
- ssn_i  input  1  slave select, active low (asynchronous).
- miso_o  output  1  MISO data.
- miso_tn  output  1  MISO tri-state: 1 = input/hi-Z, 0 = drive.
- rx_data  output  DW  received word.
- rx_valid  output  1  rx_data valid; held until accepted.
- rx_ready  input  1  user accepts rx_data.
- tx_data  input  DW  word to send.
- tx_valid  input  1  tx_data available.
- tx_ready  output  1  one-cycle pulse; tx_data is consumed when tx_valid && tx_ready.
- busy  output  1  high while state is ACTIVE.

Behaviour:
- Synchronisers:
  - sclk, mosi and ssn each pass through 2 flops, plus a third flop for edge detect.
  - Reset values: sclk = CPOL, ssn = 1, mosi = 0.
  - Pin-to-event latency is 3 clk cycles.
- Edges:
  - Leading edge = synced SCLK transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Drive edge = the other one.
  - SCLK edges are ignored unless the state is ACTIVE.
- States:
  - IDLE: ssn high.
  - IDLE -> ACTIVE on synced ssn falling.
  - ACTIVE -> IDLE on synced ssn rising.
  - ABORT: entered from reset if synced ssn is low at the first post-reset cycle; exits to IDLE only when ssn is high, so no partial frame is received after reset.
- Bit counter cnt (0..DW-1), cleared on entering ACTIVE.
- On a sample edge:
  - rx_sh <= {rx_sh[DW-2:0], mosi}.
  - If cnt == DW-1: rx_data <= completed word, rx_valid <= 1, cnt <= 0.
  - Otherwise cnt <= cnt + 1.
- Load event: takes the tx word if tx_valid, else UNDERRUN_WORD. tx_ready = load event (same cycle). A load event occurs:
  - CPHA=0: on entering ACTIVE, and on a drive edge with cnt == 0.
  - CPHA=1: on a drive edge with cnt == 0.
- On a drive edge with cnt != 0: tx_sh shifts left by one.
- miso_o = tx_sh[DW-1] registered.
- CPHA=0 prefetch: the word loaded at the trailing edge after the final sample of a frame is consumed even if ssn then rises. This is intended; the word is discarded.
- rx handshake:
  - rx_valid clears on rx_valid && rx_ready.
  - If a new word completes in the same cycle as the accept, rx_valid stays 1 with the new data.
  - If a word completes while rx_valid=1 and rx_ready=0, it overwrites rx_data (overrun).
- miso_tn = 0 in ACTIVE, 1 otherwise; changes at the state transition.
- ssn rising mid-word: partial rx discarded (no rx_valid), cnt cleared, tx_sh retained but reloaded at the next load event.
- Reset values: miso_o = 0, miso_tn = 1, rx_data = 0, rx_valid = 0, tx_ready = 0, busy = 0, cnt = 0, state IDLE (or ABORT per the rule above).

Optional Feature:
- Macro: SPI_SLAVE_STATUS_EN.
- When defined:
  - Adds output overrun (sticky; set on an rx overwrite).
  - Adds output underrun (sticky; set on a load event with tx_valid=0).
  - Adds input status_clr, which clears both flags the next cycle; a set in the same cycle wins over the clear.
  - Both flags reset to 0.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- CPOL=0/CPHA=0, DW=8: master sends 0xA5 with tx_data 0x3C preloaded, SCLK = clk/8 → rx_data = 0xA5 with a single rx_valid; MISO bits 0,0,1,1,1,1,0,0; tx_ready pulses once at ssn fall.
- CPOL=1/CPHA=1: 3-word frame MOSI 0x01, 0x80, 0xFF; tx words 0x11, 0x22, 0x33 → rx words in order, MISO carries 0x11, 0x22, 0x33, exactly 3 tx_ready pulses.
- tx_valid=0 throughout, UNDERRUN_WORD = 0x5A → MISO sends 0x5A; with SPI_SLAVE_STATUS_EN, underrun = 1 until status_clr.
- rx_ready=0 across two words 0x12, 0x34 → rx_data = 0x34, rx_valid stays 1; overrun = 1 when the macro is enabled.
- ssn raised after 5 bits → no rx_valid, miso_tn = 1 within 3 clk; next frame 0xC3 is received correctly.
- rst asserted mid-word with ssn held low → state ABORT, SCLK edges ignored, no rx_valid until ssn goes high and a new frame starts.
